uart_boot_loader: RTL and testbench

- Upstream stage of the cpu memory: receives a program image over the serial RxD line and writes it word-by-word into the BRAM through the memory write port.
- Holds the cpu core in reset while loading. Releases it once the image is complete so execution starts from address 0.
- Replaces hand-initialised memory contents for board bring-up.

---
 rtl/uart_boot_loader_if.sv | 10 +
 rtl/uart_boot_loader.sv | 254 +++++++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_boot_loader_if.sv
// Memory write port between the boot loader and the program BRAM.
// The loader drives it as master; the memory side samples it as slave.
interface uart_boot_loader_if;
  logic        mem_write_en;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;

  modport master (output mem_write_en, output mem_address, output mem_write_data);
  modport slave  (input  mem_write_en, input  mem_address, input  mem_write_data);
endinterface

// File: rtl/uart_boot_loader.sv
// Serial boot loader: receives a length-prefixed image over RxD and writes it word-wise into BRAM.
// Optional trailing XOR checksum byte is enabled by defining UART_BOOT_CHECKSUM_EN.
module uart_boot_loader #(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD         = 115200,
  parameter int NUM_OF_BYTES = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       RxD,
  input  logic                       reload,
  uart_boot_loader_if.master         mem,
  output logic                       cpu_hold,
  output logic                       load_done,
  output logic                       load_error,
  output logic [15:0]                words_loaded
);

  localparam int          BIT_CYCLES = CLK_FREQ / BAUD;
  localparam logic [15:0] BIT_LAST   = 16'(BIT_CYCLES - 1);
  localparam logic [15:0] HALF_LAST  = 16'(BIT_CYCLES / 2 - 1);
  localparam logic [16:0] MAX_WORDS  = 17'(NUM_OF_BYTES / 4);

  localparam logic [1:0] U_IDLE  = 2'd0;
  localparam logic [1:0] U_START = 2'd1;
  localparam logic [1:0] U_DATA  = 2'd2;
  localparam logic [1:0] U_STOP  = 2'd3;

  localparam logic [2:0] S_HDR_LO = 3'd0;
  localparam logic [2:0] S_HDR_HI = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;
`ifdef UART_BOOT_CHECKSUM_EN
  localparam logic [2:0] S_CHK    = 3'd6;
  localparam logic [2:0] S_FINAL  = S_CHK;
`else
  localparam logic [2:0] S_FINAL  = S_DONE;
`endif

  logic rxMeta_q, rxSync_q, rxPrev_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      rxMeta_q <= RxD;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
    end
  end

  logic [1:0]  uState_q, uState_d;
  logic [15:0] uCnt_q, uCnt_d;
  logic [2:0]  uBit_q, uBit_d;
  logic [7:0]  uShift_q, uShift_d;
  logic        byteValid_q, byteValid_d;
  logic        frameErr_q, frameErr_d;

  // Start bit is re-checked at mid-bit; every later sample lands one bit period apart.
  always_comb begin
    uState_d    = uState_q;
    uCnt_d      = uCnt_q;
    uBit_d      = uBit_q;
    uShift_d    = uShift_q;
    byteValid_d = 1'b0;
    frameErr_d  = 1'b0;
    case (uState_q)
      U_IDLE: begin
        if (rxPrev_q && !rxSync_q) begin
          uState_d = U_START;
          uCnt_d   = 16'd0;
        end
      end
      U_START: begin
        if (uCnt_q == HALF_LAST) begin
          uCnt_d   = 16'd0;
          uBit_d   = 3'd0;
          uState_d = rxSync_q ? U_IDLE : U_DATA;
        end else begin
          uCnt_d = uCnt_q + 16'd1;
        end
      end
      U_DATA: begin
        if (uCnt_q == BIT_LAST) begin
          uCnt_d   = 16'd0;
          uShift_d = {rxSync_q, uShift_q[7:1]};
          if (uBit_q == 3'd7) uState_d = U_STOP;
          else                uBit_d   = uBit_q + 3'd1;
        end else begin
          uCnt_d = uCnt_q + 16'd1;
        end
      end
      default: begin
        if (uCnt_q == BIT_LAST) begin
          uState_d    = U_IDLE;
          byteValid_d = rxSync_q;
          frameErr_d  = !rxSync_q;
        end else begin
          uCnt_d = uCnt_q + 16'd1;
        end
      end
    endcase
    if (reload) begin
      uState_d    = U_IDLE;
      byteValid_d = 1'b0;
      frameErr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      uState_q    <= U_IDLE;
      uCnt_q      <= 16'd0;
      uBit_q      <= 3'd0;
      uShift_q    <= 8'd0;
      byteValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      uState_q    <= uState_d;
      uCnt_q      <= uCnt_d;
      uBit_q      <= uBit_d;
      uShift_q    <= uShift_d;
      byteValid_q <= byteValid_d;
      frameErr_q  <= frameErr_d;
    end
  end

  logic [2:0]  state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] words_q, words_d;
  logic [1:0]  byteIdx_q, byteIdx_d;
  logic [31:0] wordBuf_q, wordBuf_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [15:0] newCount;
`ifdef UART_BOOT_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  assign newCount = {uShift_q, count_q[7:0]};

  // Address and data are latched on entry to WRITE so they hold between strobes.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    words_d   = words_q;
    byteIdx_d = byteIdx_q;
    wordBuf_d = wordBuf_q;
    addr_d    = addr_q;
    data_d    = data_q;
`ifdef UART_BOOT_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      S_HDR_LO: begin
        if (frameErr_q) begin
          state_d = S_ERR;
        end else if (byteValid_q) begin
          count_d[7:0] = uShift_q;
          state_d      = S_HDR_HI;
        end
      end
      S_HDR_HI: begin
        if (frameErr_q) begin
          state_d = S_ERR;
        end else if (byteValid_q) begin
          count_d   = newCount;
          byteIdx_d = 2'd0;
          if (newCount == 16'd0)                state_d = S_FINAL;
          else if ({1'b0, newCount} > MAX_WORDS) state_d = S_ERR;
          else                                  state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (frameErr_q) begin
          state_d = S_ERR;
        end else if (byteValid_q) begin
          wordBuf_d[{byteIdx_q, 3'b000} +: 8] = uShift_q;
`ifdef UART_BOOT_CHECKSUM_EN
          csum_d = csum_q ^ uShift_q;
`endif
          if (byteIdx_q == 2'd3) begin
            state_d   = S_WRITE;
            addr_d    = {14'd0, words_q, 2'b00};
            data_d    = {uShift_q, wordBuf_q[23:0]};
            byteIdx_d = 2'd0;
          end else begin
            byteIdx_d = byteIdx_q + 2'd1;
          end
        end
      end
      S_WRITE: begin
        words_d = words_q + 16'd1;
        state_d = (words_q + 16'd1 == count_q) ? S_FINAL : S_DATA;
      end
`ifdef UART_BOOT_CHECKSUM_EN
      S_CHK: begin
        if (frameErr_q)       state_d = S_ERR;
        else if (byteValid_q) state_d = (uShift_q == csum_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE, S_ERR: ;
      default: state_d = S_HDR_LO;
    endcase
    if (reload) begin
      state_d   = S_HDR_LO;
      words_d   = 16'd0;
      byteIdx_d = 2'd0;
`ifdef UART_BOOT_CHECKSUM_EN
      csum_d    = 8'd0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_HDR_LO;
      count_q   <= 16'd0;
      words_q   <= 16'd0;
      byteIdx_q <= 2'd0;
      wordBuf_q <= 32'd0;
      addr_q    <= 32'd0;
      data_q    <= 32'd0;
`ifdef UART_BOOT_CHECKSUM_EN
      csum_q    <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      words_q   <= words_d;
      byteIdx_q <= byteIdx_d;
      wordBuf_q <= wordBuf_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
`ifdef UART_BOOT_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  // A reload in the WRITE cycle itself must still block the strobe.
  assign mem.mem_write_en   = (state_q == S_WRITE) && !reload;
  assign mem.mem_address    = addr_q;
  assign mem.mem_write_data = data_q;
  assign cpu_hold           = (state_q != S_DONE);
  assign load_done          = (state_q == S_DONE);
  assign load_error         = (state_q == S_ERR);
  assign words_loaded       = words_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader at 16 clocks per bit; frames are hand-built byte lists.
// Checksum-frame scenarios run only when UART_BOOT_CHECKSUM_EN is defined.
module tb_uart_boot_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        RxD = 1'b1;
  logic        reload = 1'b0;
  logic        cpu_hold, load_done, load_error;
  logic [15:0] words_loaded;

  uart_boot_loader_if memIf();

  uart_boot_loader #(.CLK_FREQ(16), .BAUD(1), .NUM_OF_BYTES(1024)) dut (
    .clk          (clk),
    .reset        (reset),
    .RxD          (RxD),
    .reload       (reload),
    .mem          (memIf),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int offset = 0;
  logic [31:0] wrAddr[$];
  logic [31:0] wrData[$];
  int          wrCyc[$];
  bit          doneSeen = 1'b0;
  int          doneCyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write log and first load_done cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (memIf.mem_write_en === 1'b1) begin
      wrAddr.push_back(memIf.mem_address);
      wrData.push_back(memIf.mem_write_data);
      wrCyc.push_back(cyc);
    end
    if (load_done === 1'b1 && !doneSeen) begin
      doneSeen = 1'b1;
      doneCyc  = cyc;
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearLog();
    wrAddr.delete();
    wrData.delete();
    wrCyc.delete();
    doneSeen = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    RxD = 1'b0;
    waitCycles(16);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      waitCycles(16);
    end
    RxD = stopBit;
    waitCycles(16);
    RxD = 1'b1;
    waitCycles(2);
  endtask

  task automatic doReload();
    reload = 1'b1;
    waitCycles(1);
    reload = 1'b0;
    waitCycles(1);
    clearLog();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    waitCycles(3);
    total += 7;
    if (cpu_hold !== 1'b1) begin bad++; $display("[TB] FAIL reset_cpu_hold got %b want 1", cpu_hold); end
    if (memIf.mem_write_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_we got %b want 0", memIf.mem_write_en); end
    if (memIf.mem_address !== 32'h0) begin bad++; $display("[TB] FAIL reset_addr got %h want 0", memIf.mem_address); end
    if (memIf.mem_write_data !== 32'h0) begin bad++; $display("[TB] FAIL reset_data got %h want 0", memIf.mem_write_data); end
    if (load_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got %b want 0", load_done); end
    if (load_error !== 1'b0) begin bad++; $display("[TB] FAIL reset_error got %b want 0", load_error); end
    if (words_loaded !== 16'd0) begin bad++; $display("[TB] FAIL reset_words got %0d want 0", words_loaded); end
    reset = 1'b1;
    waitCycles(4);
    clearLog();
  endtask

  task automatic test_two_words();
    logic [31:0] a0, d0, a1, d1;
    sendByte(8'h02, 1'b1); sendByte(8'h00, 1'b1);
    sendByte(8'h44, 1'b1); sendByte(8'h33, 1'b1); sendByte(8'h22, 1'b1); sendByte(8'h11, 1'b1);
    sendByte(8'hDD, 1'b1); sendByte(8'hCC, 1'b1); sendByte(8'hBB, 1'b1); sendByte(8'hAA, 1'b1);
`ifdef UART_BOOT_CHECKSUM_EN
    sendByte(8'h44, 1'b1);
`endif
    waitCycles(4);
    a0 = (wrAddr.size() > 0) ? wrAddr[0] : 32'hxxxxxxxx;
    d0 = (wrData.size() > 0) ? wrData[0] : 32'hxxxxxxxx;
    a1 = (wrAddr.size() > 1) ? wrAddr[1] : 32'hxxxxxxxx;
    d1 = (wrData.size() > 1) ? wrData[1] : 32'hxxxxxxxx;
    total += 8;
    if (wrAddr.size() != 2) begin bad++; $display("[TB] FAIL two_write_count got %0d want 2", wrAddr.size()); end
    if (a0 !== 32'h0) begin bad++; $display("[TB] FAIL two_addr0 got %h want 00000000", a0); end
    if (d0 !== 32'h11223344) begin bad++; $display("[TB] FAIL two_data0 got %h want 11223344", d0); end
    if (a1 !== 32'h4) begin bad++; $display("[TB] FAIL two_addr1 got %h want 00000004", a1); end
    if (d1 !== 32'hAABBCCDD) begin bad++; $display("[TB] FAIL two_data1 got %h want aabbccdd", d1); end
    if (words_loaded !== 16'd2) begin bad++; $display("[TB] FAIL two_words got %0d want 2", words_loaded); end
    if (load_done !== 1'b1) begin bad++; $display("[TB] FAIL two_done got %b want 1", load_done); end
    if (cpu_hold !== 1'b0) begin bad++; $display("[TB] FAIL two_hold got %b want 0", cpu_hold); end
`ifndef UART_BOOT_CHECKSUM_EN
    total++;
    if (wrCyc.size() != 2 || !doneSeen || doneCyc != wrCyc[1] + 1) begin
      bad++;
      $display("[TB] FAIL two_done_timing got done cycle %0d want one after last write", doneCyc);
    end
`endif
  endtask

  task automatic test_zero_count();
    doReload();
    total++;
    if (cpu_hold !== 1'b1) begin bad++; $display("[TB] FAIL reload_hold got %b want 1", cpu_hold); end
    sendByte(8'h00, 1'b1); sendByte(8'h00, 1'b1);
`ifdef UART_BOOT_CHECKSUM_EN
    sendByte(8'h00, 1'b1);
`endif
    total += 4;
    if (wrAddr.size() != 0) begin bad++; $display("[TB] FAIL zero_writes got %0d want 0", wrAddr.size()); end
    if (load_done !== 1'b1) begin bad++; $display("[TB] FAIL zero_done got %b want 1", load_done); end
    if (cpu_hold !== 1'b0) begin bad++; $display("[TB] FAIL zero_hold got %b want 0", cpu_hold); end
    if (words_loaded !== 16'd0) begin bad++; $display("[TB] FAIL zero_words got %0d want 0", words_loaded); end
  endtask

  task automatic test_over_limit();
    logic [31:0] d0;
    doReload();
    sendByte(8'h01, 1'b1); sendByte(8'h01, 1'b1);
    waitCycles(2);
    total += 4;
    if (load_error !== 1'b1) begin bad++; $display("[TB] FAIL limit_error got %b want 1", load_error); end
    if (cpu_hold !== 1'b1) begin bad++; $display("[TB] FAIL limit_hold got %b want 1", cpu_hold); end
    if (load_done !== 1'b0) begin bad++; $display("[TB] FAIL limit_done got %b want 0", load_done); end
    if (wrAddr.size() != 0) begin bad++; $display("[TB] FAIL limit_writes got %0d want 0", wrAddr.size()); end
    doReload();
    total++;
    if (load_error !== 1'b0) begin bad++; $display("[TB] FAIL limit_clear got %b want 0", load_error); end
    sendByte(8'h01, 1'b1); sendByte(8'h00, 1'b1);
    sendByte(8'h78, 1'b1); sendByte(8'h56, 1'b1); sendByte(8'h34, 1'b1); sendByte(8'h12, 1'b1);
`ifdef UART_BOOT_CHECKSUM_EN
    sendByte(8'h08, 1'b1);
`endif
    waitCycles(2);
    d0 = (wrData.size() > 0) ? wrData[0] : 32'hxxxxxxxx;
    total += 2;
    if (d0 !== 32'h12345678) begin bad++; $display("[TB] FAIL limit_reload_data got %h want 12345678", d0); end
    if (load_done !== 1'b1) begin bad++; $display("[TB] FAIL limit_reload_done got %b want 1", load_done); end
  endtask

  task automatic test_glitch();
    int s;
    logic [31:0] a0, d0;
    doReload();
    RxD = 1'b0;
    waitCycles(4);
    RxD = 1'b1;
    waitCycles(40);
    sendByte(8'h01, 1'b1); sendByte(8'h00, 1'b1);
    sendByte(8'hEF, 1'b1); sendByte(8'hBE, 1'b1); sendByte(8'hAD, 1'b1);
    s = cyc;
    sendByte(8'hDE, 1'b1);
    if (wrCyc.size() > 0) offset = wrCyc[0] - s;
`ifdef UART_BOOT_CHECKSUM_EN
    sendByte(8'h22, 1'b1);
`endif
    waitCycles(2);
    a0 = (wrAddr.size() > 0) ? wrAddr[0] : 32'hxxxxxxxx;
    d0 = (wrData.size() > 0) ? wrData[0] : 32'hxxxxxxxx;
    total += 4;
    if (wrAddr.size() != 1) begin bad++; $display("[TB] FAIL glitch_writes got %0d want 1", wrAddr.size()); end
    if (a0 !== 32'h0) begin bad++; $display("[TB] FAIL glitch_addr got %h want 00000000", a0); end
    if (d0 !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL glitch_data got %h want deadbeef", d0); end
    if (load_done !== 1'b1) begin bad++; $display("[TB] FAIL glitch_done got %b want 1", load_done); end
  endtask

  task automatic test_framing();
    doReload();
    sendByte(8'h02, 1'b1); sendByte(8'h00, 1'b1);
    sendByte(8'h55, 1'b0);
    sendByte(8'h66, 1'b1); sendByte(8'h77, 1'b1); sendByte(8'h88, 1'b1); sendByte(8'h99, 1'b1);
    total += 4;
    if (load_error !== 1'b1) begin bad++; $display("[TB] FAIL frame_error got %b want 1", load_error); end
    if (cpu_hold !== 1'b1) begin bad++; $display("[TB] FAIL frame_hold got %b want 1", cpu_hold); end
    if (wrAddr.size() != 0) begin bad++; $display("[TB] FAIL frame_writes got %0d want 0", wrAddr.size()); end
    if (words_loaded !== 16'd0) begin bad++; $display("[TB] FAIL frame_words got %0d want 0", words_loaded); end
  endtask

  task automatic test_reload_on_write();
    logic [31:0] d0;
    doReload();
    sendByte(8'h01, 1'b1); sendByte(8'h00, 1'b1);
    sendByte(8'hEF, 1'b1); sendByte(8'hBE, 1'b1); sendByte(8'hAD, 1'b1);
    fork
      sendByte(8'hDE, 1'b1);
      begin
        repeat (offset) @(posedge clk);
        #1 reload = 1'b1;
        @(posedge clk);
        #1 reload = 1'b0;
      end
    join
    waitCycles(4);
    total += 5;
    if (offset <= 0) begin bad++; $display("[TB] FAIL reload_offset got %0d want positive", offset); end
    if (wrAddr.size() != 0) begin bad++; $display("[TB] FAIL reload_write_suppressed got %0d writes want 0", wrAddr.size()); end
    if (words_loaded !== 16'd0) begin bad++; $display("[TB] FAIL reload_words got %0d want 0", words_loaded); end
    if (cpu_hold !== 1'b1) begin bad++; $display("[TB] FAIL reload_hold2 got %b want 1", cpu_hold); end
    if (load_done !== 1'b0) begin bad++; $display("[TB] FAIL reload_done got %b want 0", load_done); end
    sendByte(8'h01, 1'b1); sendByte(8'h00, 1'b1);
    sendByte(8'hEF, 1'b1); sendByte(8'hBE, 1'b1); sendByte(8'hAD, 1'b1); sendByte(8'hDE, 1'b1);
`ifdef UART_BOOT_CHECKSUM_EN
    sendByte(8'h22, 1'b1);
`endif
    waitCycles(2);
    d0 = (wrData.size() > 0) ? wrData[0] : 32'hxxxxxxxx;
    total += 2;
    if (d0 !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL reload_then_data got %h want deadbeef", d0); end
    if (load_done !== 1'b1) begin bad++; $display("[TB] FAIL reload_then_done got %b want 1", load_done); end
  endtask

`ifdef UART_BOOT_CHECKSUM_EN
  task automatic test_checksum();
    logic [31:0] d0;
    doReload();
    sendByte(8'h01, 1'b1); sendByte(8'h00, 1'b1);
    sendByte(8'h01, 1'b1); sendByte(8'h02, 1'b1); sendByte(8'h04, 1'b1); sendByte(8'h08, 1'b1);
    sendByte(8'h0F, 1'b1);
    d0 = (wrData.size() > 0) ? wrData[0] : 32'hxxxxxxxx;
    total += 2;
    if (d0 !== 32'h08040201) begin bad++; $display("[TB] FAIL csum_ok_data got %h want 08040201", d0); end
    if (load_done !== 1'b1) begin bad++; $display("[TB] FAIL csum_ok_done got %b want 1", load_done); end
    doReload();
    sendByte(8'h01, 1'b1); sendByte(8'h00, 1'b1);
    sendByte(8'h01, 1'b1); sendByte(8'h02, 1'b1); sendByte(8'h04, 1'b1); sendByte(8'h08, 1'b1);
    sendByte(8'h0E, 1'b1);
    total += 3;
    if (wrData.size() != 1) begin bad++; $display("[TB] FAIL csum_bad_writes got %0d want 1", wrData.size()); end
    if (load_error !== 1'b1) begin bad++; $display("[TB] FAIL csum_bad_error got %b want 1", load_error); end
    if (cpu_hold !== 1'b1) begin bad++; $display("[TB] FAIL csum_bad_hold got %b want 1", cpu_hold); end
  endtask
`endif

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_two_words();
    test_zero_count();
    test_over_limit();
    test_glitch();
    test_framing();
    test_reload_on_write();
`ifdef UART_BOOT_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
